dmux_n_reg: RTL and testbench
=============================

Name: dmux_n_reg

Overview:
- Parametrised 1-to-N demultiplexer. Successor of the 2-output combinational demux.
- Routes an LARGURA-bit word to one of N_SAIDAS outputs. Each output has a one-word output register with a valid/ready handshake.
- Two routing modes: explicit select, or round-robin distribution.
- Sits between a single producer and N consumers, e.g. spreading work across parallel units in the course datapath.

Parameters:
- LARGURA, 8, data word width in bits.
- N_SAIDAS, 4, number of output channels (2..16).
- SEL_W, 2, select/pointer width; must satisfy 2**SEL_W >= N_SAIDAS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- entrada  input  LARGURA  input data word.
- in_valid  input  1  producer offers entrada.
- in_ready  output  1  block accepts entrada this cycle.
- sel  input  SEL_W  target channel in modo=0.
- modo  input  1  0 = route by sel; 1 = round-robin by internal pointer.
- saida  output  N_SAIDAS*LARGURA  flattened output words; channel k occupies bits [k*LARGURA +: LARGURA].
- out_valid  output  N_SAIDAS  channel k holds a word.
- out_ready  input  N_SAIDAS  consumer k takes its word.
- ptr  output  SEL_W  current round-robin pointer.
- erro  output  1  sticky flag: in_valid=1 with sel >= N_SAIDAS in modo=0.

Behaviour:
- Reset (rst=1 at a rising edge): out_valid=0, saida=0, ptr=0, erro=0. Any words held in slots are discarded. rst dominates all other inputs in the same cycle. in_ready is 0 while rst is high.
- Target channel t is ptr when modo=1, and sel when modo=0. modo is sampled each cycle with no state change on toggle; ptr keeps its value.
- in_ready is combinational: in_ready = !rst && t valid && (!out_valid[t] || out_ready[t]). An occupied slot accepts a new word in the same cycle it drains (full throughput).
- t is valid when t < N_SAIDAS. If sel >= N_SAIDAS in modo=0:
  - in_ready=0 and nothing is accepted.
  - If in_valid=1, erro is set and stays set until rst.
- Transfer in: when in_valid && in_ready, at the edge saida[t] <= entrada and out_valid[t] <= 1. Latency is exactly 1 cycle from accept to out_valid.
- Transfer out: when out_valid[k] && out_ready[k] and there is no simultaneous write to k, out_valid[k] <= 0 at the edge. saida[k] keeps its last value (don't-care while invalid).
- Simultaneous drain and write on the same k: out_valid[k] stays 1 and saida[k] takes the new word. No bubble and no loss.
- Stability: while out_valid[k]=1 && out_ready[k]=0, saida[k] and out_valid[k] must not change.
- Channels are independent: a stall on channel j never affects draining or writing of channel k≠j.
- Round-robin pointer: advances only on an accepted transfer while modo=1. Update is ptr <= (ptr==N_SAIDAS-1) ? 0 : ptr+1, i.e. wrap at N_SAIDAS, not 2**SEL_W.
  - If the target slot is full and stalled, in_ready=0 and ptr holds. Strict order: the block does not skip to another free channel.
- At most one input word is accepted per cycle.
- No combinational path from entrada to saida. out_valid and saida are driven only by registers.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1, entrada=8'hAA -> out_valid=4'b0000, ptr=0, erro=0, in_ready=0; no word appears after release until a new accept.
2. Select mode, all out_ready=1: modo=0, send 8'h11/sel=2, then 8'h22/sel=0 -> out_valid[2]=1 with saida[2]=8'h11 one cycle after the first accept; out_valid[0]=1 with saida[0]=8'h22 next cycle; ptr stays 0.
3. Backpressure: modo=0, sel=1, out_ready[1]=0, send 8'h33 then 8'h44 -> 8'h33 latched, in_ready=0 for 8'h44 and saida[1] stays 8'h33. Raise out_ready[1] -> 8'h44 accepted that same cycle and saida[1]=8'h44 next edge with out_valid[1] continuously 1.
4. Round-robin wrap: modo=1, all out_ready=1, send 6 words 8'h01..8'h06 -> they land on channels 0,1,2,3,0,1; ptr sequence 0,1,2,3,0,1,2.
5. Round-robin stall: modo=1, ptr=2, out_valid[2]=1, out_ready[2]=0 -> in_ready=0, ptr stays 2, channels 0, 1 and 3 keep draining normally.
6. Invalid select with N_SAIDAS=3, SEL_W=2: modo=0, sel=3, in_valid=1 -> in_ready=0, no out_valid change, erro=1 from the next cycle until rst.

Source files
------------

// File: rtl/dmux_n_reg.sv
// 1-to-N demultiplexer with a one-word registered slot per output channel.
// Words are routed by explicit select or by a round-robin pointer, with a valid/ready handshake on every side.
module dmux_n_reg #(
   parameter int LARGURA  = 8,
   parameter int N_SAIDAS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [LARGURA-1:0]            entrada,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SEL_W-1:0]              sel,
   input  logic                          modo,
   output logic [N_SAIDAS*LARGURA-1:0]   saida,
   output logic [N_SAIDAS-1:0]           out_valid,
   input  logic [N_SAIDAS-1:0]           out_ready,
   output logic [SEL_W-1:0]              ptr,
   output logic                          erro
);

   // Last legal pointer value; the pointer wraps here rather than at 2**SEL_W.
   localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_SAIDAS - 1);

   logic [SEL_W-1:0]             target_s;
   logic [N_SAIDAS-1:0]          sel_oh_s;
   logic                         tgt_ok_s;
   logic                         in_ready_s;
   logic                         accept_s;
   logic [N_SAIDAS-1:0]          wr_s;

   logic [N_SAIDAS-1:0]          out_valid_r;
   logic [N_SAIDAS*LARGURA-1:0]  saida_r;
   logic [SEL_W-1:0]             ptr_r;
   logic                         erro_r;

   // Choose the target channel from the routing mode.
   always_comb begin
      target_s = {SEL_W{1'b0}};
      if (modo) begin
         target_s = ptr_r;
      end else begin
         target_s = sel;
      end
   end

   // One-hot decode of the target; an all-zero result marks an out-of-range select.
   always_comb begin
      sel_oh_s = {N_SAIDAS{1'b0}};
      for (int k = 0; k < N_SAIDAS; k++) begin
         if (target_s == SEL_W'(k)) begin
            sel_oh_s[k] = 1'b1;
         end else begin
            sel_oh_s[k] = 1'b0;
         end
      end
   end

   // Input handshake: the target slot is empty or is being drained this cycle.
   always_comb begin
      tgt_ok_s   = |sel_oh_s;
      in_ready_s = 1'b0;
      if (rst) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = |(sel_oh_s & (~out_valid_r | out_ready));
      end
      accept_s = in_valid & in_ready_s;
      if (accept_s) begin
         wr_s = sel_oh_s;
      end else begin
         wr_s = {N_SAIDAS{1'b0}};
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_SAIDAS; g++) begin : g_slot
         // Per-channel slot: a write wins over a drain so a word can be replaced in its drain cycle.
         always_ff @(posedge clk) begin
            if (rst) begin
               out_valid_r[g]                  <= 1'b0;
               saida_r[g*LARGURA +: LARGURA]   <= {LARGURA{1'b0}};
            end else if (wr_s[g]) begin
               out_valid_r[g]                  <= 1'b1;
               saida_r[g*LARGURA +: LARGURA]   <= entrada;
            end else if (out_ready[g]) begin
               out_valid_r[g]                  <= 1'b0;
            end
         end
      end
   endgenerate

   // Round-robin pointer moves only on an accepted word in round-robin mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {SEL_W{1'b0}};
      end else if (accept_s && modo) begin
         if (ptr_r == PTR_LAST) begin
            ptr_r <= {SEL_W{1'b0}};
         end else begin
            ptr_r <= ptr_r + {{(SEL_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Sticky error on an offered word with an out-of-range select.
   always_ff @(posedge clk) begin
      if (rst) begin
         erro_r <= 1'b0;
      end else if (in_valid && !modo && !tgt_ok_s) begin
         erro_r <= 1'b1;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign saida     = saida_r;
   assign ptr       = ptr_r;
   assign erro      = erro_r;

endmodule

// File: tb/tb_dmux_n_reg.sv
// Randomized scoreboard bench for dmux_n_reg, plus a short directed run on a 3-channel instance
// to exercise out-of-range select and pointer wrap below 2**SEL_W.
module tb_dmux_n_reg;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     entrada = 8'h00;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [1:0]     sel = 2'd0;
   logic           modo = 1'b0;
   logic [31:0]    saida;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready = 4'b0000;
   logic [1:0]     ptr;
   logic           erro;

   logic           rst3 = 1'b1;
   logic [7:0]     entrada3 = 8'h00;
   logic           in_valid3 = 1'b0;
   logic           in_ready3;
   logic [1:0]     sel3 = 2'd0;
   logic           modo3 = 1'b0;
   logic [23:0]    saida3;
   logic [2:0]     out_valid3;
   logic [2:0]     out_ready3 = 3'b111;
   logic [1:0]     ptr3;
   logic           erro3;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] q [N][$];
   int         occ [N];
   int         ptr_m = 0;
   bit         erro_m = 1'b0;

   always #5 clk = ~clk;

   dmux_n_reg #(.LARGURA(8), .N_SAIDAS(4), .SEL_W(2)) u_dut (
      .clk(clk), .rst(rst), .entrada(entrada), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .modo(modo), .saida(saida), .out_valid(out_valid), .out_ready(out_ready),
      .ptr(ptr), .erro(erro)
   );

   dmux_n_reg #(.LARGURA(8), .N_SAIDAS(3), .SEL_W(2)) u_dut3 (
      .clk(clk), .rst(rst3), .entrada(entrada3), .in_valid(in_valid3), .in_ready(in_ready3),
      .sel(sel3), .modo(modo3), .saida(saida3), .out_valid(out_valid3), .out_ready(out_ready3),
      .ptr(ptr3), .erro(erro3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: channel occupancy, pointer and error flag from the handshake rules.
   initial begin
      for (int k = 0; k < N; k++) occ[k] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("in_ready_rst", {31'd0, in_ready}, 32'd0);
            for (int k = 0; k < N; k++) begin
               occ[k] = 0;
               q[k].delete();
            end
            ptr_m  = 0;
            erro_m = 1'b0;
         end else begin
            int t;
            bit exp_rdy;
            logic [3:0] occ_v;
            for (int k = 0; k < N; k++) occ_v[k] = (occ[k] != 0);
            chk("out_valid", {28'd0, out_valid}, {28'd0, occ_v});
            chk("ptr", {30'd0, ptr}, ptr_m);
            chk("erro", {31'd0, erro}, {31'd0, erro_m});
            t = modo ? ptr_m : int'(sel);
            exp_rdy = (t < N) && ((occ[t] == 0) || out_ready[t]);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int k = 0; k < N; k++)
               if (occ[k] != 0 && out_ready[k]) occ[k] = 0;
            if (in_valid && exp_rdy) begin
               q[t].push_back(entrada);
               occ[t] = 1;
               if (modo) ptr_m = (ptr_m + 1) % N;
            end
            if (in_valid && !modo && t >= N) erro_m = 1'b1;
         end
      end
   end

   // Monitor: every word taken by a consumer must be the oldest one routed to that channel.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int k = 0; k < N; k++) begin
               if (out_valid[k] && out_ready[k]) begin
                  if (q[k].size() == 0) begin
                     chk("unexpected_word", {24'd0, saida[k*8 +: 8]}, 32'hFFFF_FFFF);
                  end else begin
                     logic [7:0] e;
                     e = q[k].pop_front();
                     chk($sformatf("saida[%0d]", k), {24'd0, saida[k*8 +: 8]}, {24'd0, e});
                  end
               end
            end
         end
      end
   end

   initial begin
      // Reset held with a word offered; nothing may be accepted.
      in_valid = 1'b1;
      entrada  = 8'hAA;
      out_ready = 4'b1111;
      rst3 = 1'b1;
      step();
      step();
      rst  = 1'b0;
      rst3 = 1'b0;
      in_valid = 1'b0;
      step();

      for (int c = 0; c < 900; c++) begin
         in_valid = ($urandom_range(3) != 0);
         entrada  = 8'($urandom);
         sel      = 2'($urandom);
         if (c < 300)      modo = 1'b0;
         else if (c < 600) modo = 1'b1;
         else              modo = 1'($urandom);
         case ((c / 40) % 3)
            0:       out_ready = 4'b1111;
            1:       out_ready = 4'($urandom);
            2:       out_ready = 4'b1111 & ~(4'b0001 << ((c / 120) % 4));
            default: out_ready = 4'b1111;
         endcase
         rst = (c > 600) && ($urandom_range(96) == 0);
         step();
      end

      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 4'b1111;
      repeat (4) step();
      @(negedge clk);
      for (int k = 0; k < N; k++) chk($sformatf("drained[%0d]", k), q[k].size(), 32'd0);

      // Three-channel instance: sel=3 is out of range.
      rst3 = 1'b1;
      step();
      rst3 = 1'b0;
      modo3 = 1'b0;
      sel3 = 2'd3;
      in_valid3 = 1'b1;
      entrada3 = 8'h5A;
      @(negedge clk);
      chk("n3_in_ready_bad_sel", {31'd0, in_ready3}, 32'd0);
      chk("n3_erro_before", {31'd0, erro3}, 32'd0);
      step();
      in_valid3 = 1'b0;
      @(negedge clk);
      chk("n3_erro_set", {31'd0, erro3}, 32'd1);
      chk("n3_no_valid", {29'd0, out_valid3}, 32'd0);
      step();
      sel3 = 2'd2;
      in_valid3 = 1'b1;
      entrada3 = 8'h77;
      @(negedge clk);
      chk("n3_in_ready_sel2", {31'd0, in_ready3}, 32'd1);
      step();
      in_valid3 = 1'b0;
      @(negedge clk);
      chk("n3_valid_ch2", {29'd0, out_valid3}, 32'h4);
      chk("n3_saida_ch2", {24'd0, saida3[23:16]}, 32'h77);
      chk("n3_erro_sticky", {31'd0, erro3}, 32'd1);
      chk("n3_ptr_sel_mode", {30'd0, ptr3}, 32'd0);

      // Round-robin wraps at 3, not 4.
      modo3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         in_valid3 = 1'b1;
         entrada3 = 8'(8'h10 + i);
         @(negedge clk);
         chk($sformatf("n3_ptr_seq%0d", i), {30'd0, ptr3}, i % 3);
      end
      step();
      in_valid3 = 1'b0;
      @(negedge clk);
      chk("n3_ptr_after", {30'd0, ptr3}, 32'd2);
      chk("n3_saida_ch0", {24'd0, saida3[7:0]}, 32'h13);
      chk("n3_saida_ch1", {24'd0, saida3[15:8]}, 32'h14);
      rst3 = 1'b1;
      step();
      rst3 = 1'b0;
      @(negedge clk);
      chk("n3_erro_cleared", {31'd0, erro3}, 32'd0);
      chk("n3_ptr_cleared", {30'd0, ptr3}, 32'd0);
      chk("n3_valid_cleared", {29'd0, out_valid3}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
